spi_frame_sequencer: RTL
========================

# spi_frame_sequencer

Control sequencer for the SPI peripheral datapath: shift register, address latch, data memory and MISO output buffer. It watches the conditioned chip select and SCLK edge strobes, counts bits, decodes the read/write command, and drives the mode and enable strobes that move one byte per frame between the shift register and memory. It aborts cleanly when chip select deasserts early.

## Interface
- `ADDR_W`, default 7: memory address width. The command byte is {address[ADDR_W-1:0], rw}.
- `DATA_W`, default 8: data byte width; also the bit count per phase.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs_n`  in  1  conditioned chip select, active low, synchronous to `clk`.
- `sclk_posedge`  in  1  single-cycle strobe, conditioned SCLK rising edge.
- `sr_lsb`  in  1  shift register parallel-out bit 0, the rw bit after the command byte.
- `sr_mode`  out  2  shift register mode: 00 HOLD, 01 SHIFT (serial-in on `sclk_posedge`), 10 LOAD (parallel load from memory), 11 unused.
- `addr_we`  out  1  address latch write enable, one-cycle pulse.
- `dm_we`  out  1  data memory write enable, one-cycle pulse.
- `miso_oe`  out  1  MISO buffer enable.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse when a complete read or write finishes.
- `frame_abort`  out  1  one-cycle pulse when `cs_n` rises mid-frame.

## Operation
- States: IDLE, GET_CMD, LATCH_ADDR, MEM_WAIT, LOAD, READ_SHIFT, WRITE_SHIFT, COMMIT, DONE.
- Bit counter: 0..DATA_W, width clog2(DATA_W)+1. Cleared on every phase entry. Increments on `sclk_posedge` only in GET_CMD, READ_SHIFT and WRITE_SHIFT.
- IDLE: all outputs 0. If `cs_n`==0, go to GET_CMD with the counter cleared. `sclk_posedge` is ignored in IDLE.
- GET_CMD: `sr_mode`=SHIFT. When the counter reaches DATA_W (the 8th posedge), go to LATCH_ADDR.
- LATCH_ADDR: one cycle. `addr_we`=1, `sr_mode`=HOLD. Samples `sr_lsb` as rw. rw=1 goes to MEM_WAIT; rw=0 goes to WRITE_SHIFT.
- MEM_WAIT: one cycle for synchronous memory read latency. `sr_mode`=HOLD.
- LOAD: one cycle. `sr_mode`=LOAD, `miso_oe`=1. Then go to READ_SHIFT.
- READ_SHIFT: `sr_mode`=SHIFT, `miso_oe`=1. After DATA_W posedges, pulse `frame_done` and go to DONE.
- WRITE_SHIFT: `sr_mode`=SHIFT. After DATA_W posedges, go to COMMIT.
- COMMIT: one cycle. `dm_we`=1, `sr_mode`=HOLD, `frame_done`=1. Then go to DONE.
- DONE: `sr_mode`=HOLD, outputs idle, `busy`=1. Extra SCLK edges are ignored. When `cs_n`==1, go to IDLE.
- Abort: `cs_n`==1 in GET_CMD, LATCH_ADDR, MEM_WAIT, LOAD, READ_SHIFT, WRITE_SHIFT or COMMIT goes to IDLE next cycle.
  - `frame_abort` pulses that cycle.
  - No `dm_we` or `addr_we` is issued in that cycle, including in COMMIT or LATCH_ADDR.
  - Abort has priority over every other transition and over a coincident `sclk_posedge`.
- Only one frame per chip-select assertion. A new frame requires `cs_n` to return high and then go low again.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, counter 0. `sr_mode`=00; `addr_we`, `dm_we`, `miso_oe`, `busy`, `frame_done`, `frame_abort` all 0.
- Outputs are Moore (decoded from registered state). The exception is `frame_abort`, which is registered and asserts in the first IDLE cycle after the abort.
- A `cs_n` fall coincident with `sclk_posedge` in IDLE: that edge is not counted.
- `addr_we` asserts in the cycle after the clk edge that registers the 8th posedge. The shift register has already absorbed bit 8 by then.
- Write latency: `dm_we` is high exactly 1 cycle after the clk edge that registers the 16th counted posedge.
- Read latency: LOAD is the 3rd cycle after the 8th posedge (LATCH_ADDR, MEM_WAIT, LOAD). `miso_oe` rises with LOAD and falls on entry to DONE.
- `frame_done` is one cycle wide, in COMMIT (write) or on the READ_SHIFT-to-DONE transition (read).

## Test plan
- Write: cs_n low, shift 0x14 (addr 0x0A, rw=0) then 0x5A -> one `addr_we` pulse after bit 8; one `dm_we` pulse 1 cycle after bit 16; `frame_done`=1 in the same cycle; no `miso_oe`.
- Read: shift 0x15 (addr 0x0A, rw=1) -> `addr_we`, then HOLD, then `sr_mode`=10 for exactly 1 cycle; `miso_oe` high for LOAD plus 8 posedges; `frame_done` pulse; `dm_we` never asserted.
- Abort during write data: raise cs_n after 12 posedges -> IDLE next cycle, `frame_abort`=1 for 1 cycle, `dm_we` stays 0; next frame behaves normally.
- Edge coincidence: cs_n rises in the COMMIT-entry cycle together with `sclk_posedge` -> no `dm_we`, `frame_abort` pulses.
- Extra clocks: 20 posedges in a write frame -> single `dm_we`; posedges 17-20 ignored in DONE; `busy` stays 1 until cs_n high.
- Reset mid-read: assert `rst_n`=0 during READ_SHIFT -> all outputs 0 immediately (asynchronously); after release, state IDLE with cs_n still low; no frame starts until cs_n toggles high then low.

Source files
------------

// File: rtl/spi_frame_sequencer.sv
// -----------------------------------------------------------------------------
// spi_frame_sequencer
//
// Control sequencer for the SPI peripheral datapath. It counts conditioned SCLK
// rising edges while chip select is low, decodes the command byte
// {address, rw}, and drives the shift-register mode, address-latch and
// data-memory strobes that move one data byte per frame. If chip select rises
// mid-frame, the frame is dropped cleanly.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   cs_n          conditioned chip select, active low, synchronous to clk
//   sclk_posedge  one-cycle strobe per SCLK rising edge
//   sr_lsb        shift register bit 0 (rw bit once the command is shifted in)
//   sr_mode       shift register mode: 00 HOLD, 01 SHIFT, 10 LOAD
//   addr_we       address latch write enable (one-cycle pulse)
//   dm_we         data memory write enable (one-cycle pulse)
//   miso_oe       MISO buffer enable
//   busy          high whenever the sequencer is not idle
//   frame_done    one-cycle pulse when a read or write completes
//   frame_abort   one-cycle pulse, first idle cycle after an early cs_n rise
// -----------------------------------------------------------------------------
module spi_frame_sequencer #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       sclk_posedge,
    input  logic       sr_lsb,
    output logic [1:0] sr_mode,
    output logic       addr_we,
    output logic       dm_we,
    output logic       miso_oe,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort
);

    // Command phase length follows the command byte layout {address, rw}.
    localparam int unsigned CMD_BITS = ADDR_W + 1;
    localparam int unsigned MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int unsigned CNT_W    = $clog2(MAX_BITS) + 1;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        LATCH_ADDR,
        MEM_WAIT,
        LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        COMMIT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SR_HOLD  = 2'b00,
        SR_SHIFT = 2'b01,
        SR_LOAD  = 2'b10
    } sr_mode_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             armed_q, armed_d;
    logic             abort_q, abort_d;
    logic             rd_done_q, rd_done_d;
    logic             counting;
    sr_mode_e         sr_mode_s;

    assign cnt_inc  = cnt_q + 1'b1;
    assign counting = (state_q == GET_CMD) || (state_q == READ_SHIFT) ||
                      (state_q == WRITE_SHIFT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b0;
            abort_q   <= 1'b0;
            rd_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            abort_q   <= abort_d;
            rd_done_q <= rd_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!cs_n && armed_q) state_d = GET_CMD;
            end
            GET_CMD: begin
                if (cs_n)
                    state_d = IDLE;
                else if (sclk_posedge && (cnt_inc == CNT_W'(CMD_BITS)))
                    state_d = LATCH_ADDR;
            end
            LATCH_ADDR: begin
                if (cs_n)        state_d = IDLE;
                else if (sr_lsb) state_d = MEM_WAIT;
                else             state_d = WRITE_SHIFT;
            end
            MEM_WAIT: state_d = cs_n ? IDLE : LOAD;
            LOAD:     state_d = cs_n ? IDLE : READ_SHIFT;
            READ_SHIFT: begin
                if (cs_n)
                    state_d = IDLE;
                else if (sclk_posedge && (cnt_inc == CNT_W'(DATA_W)))
                    state_d = DONE;
            end
            WRITE_SHIFT: begin
                if (cs_n)
                    state_d = IDLE;
                else if (sclk_posedge && (cnt_inc == CNT_W'(DATA_W)))
                    state_d = COMMIT;
            end
            COMMIT: state_d = cs_n ? IDLE : DONE;
            DONE:   if (cs_n) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counter restarts on every phase change so each phase counts from 0.
        if (state_d != state_q)
            cnt_d = '0;
        else if (counting && sclk_posedge)
            cnt_d = cnt_inc;
        else
            cnt_d = cnt_q;

        // A frame may only start after cs_n has been seen high (also after
        // reset), so one chip-select assertion yields at most one frame.
        if (cs_n)
            armed_d = 1'b1;
        else if ((state_q == IDLE) && (state_d == GET_CMD))
            armed_d = 1'b0;
        else
            armed_d = armed_q;

        abort_d   = cs_n && (state_q != IDLE) && (state_q != DONE);
        rd_done_d = (state_q == READ_SHIFT) && (state_d == DONE);
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        sr_mode_s  = SR_HOLD;
        addr_we    = 1'b0;
        dm_we      = 1'b0;
        miso_oe    = 1'b0;
        frame_done = rd_done_q;
        busy       = (state_q != IDLE);
        unique case (state_q)
            GET_CMD:     sr_mode_s = SR_SHIFT;
            // Write strobes are withheld in a cycle where cs_n has already
            // risen, so an aborted frame never touches the latch or memory.
            LATCH_ADDR:  addr_we = !cs_n;
            LOAD: begin
                sr_mode_s = SR_LOAD;
                miso_oe   = 1'b1;
            end
            READ_SHIFT: begin
                sr_mode_s = SR_SHIFT;
                miso_oe   = 1'b1;
            end
            WRITE_SHIFT: sr_mode_s = SR_SHIFT;
            COMMIT: begin
                dm_we      = !cs_n;
                frame_done = !cs_n;
            end
            default: ;
        endcase
    end

    assign sr_mode     = sr_mode_s;
    assign frame_abort = abort_q;

endmodule
